// File: rtl/dht11_responder.sv
// rtl/dht11_responder.sv - DHT11 sensor emulator driving an open-drain single-wire line
// Optional corrupt_checksum input is enabled by defining DHT11_FAULT_INJECT_EN.
module dht11_responder #(
    parameter int TICKS_PER_US  = 50,
    parameter int MIN_START_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int ACK_US        = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 27,
    parameter int BIT1_HIGH_US  = 70
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_FAULT_INJECT_EN
    input  logic       corrupt_checksum,
`endif
    inout  wire        transmission_line,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, WAIT_RESP, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    // The IDLE cycle that first saw the low line already counts toward the host low time.
    localparam logic [PW-1:0] PRE_START = (TICKS_PER_US > 1) ? PW'(1) : PW'(0);
    localparam logic [14:0]   US_START  = (TICKS_PER_US > 1) ? 15'd0 : 15'd1;

    state_t        state, state_n;
    logic          line_s1, line_s2, armed;
    logic [PW-1:0] pre;
    logic [14:0]   us_cnt;
    logic [14:0]   phase_len;
    logic [39:0]   frame;
    logic [5:0]    bit_idx;
    logic [7:0]    checksum, checksum_tx;
    logic          tick, phase_done, latch, done_set;

    assign checksum = hum_int + hum_dec + temp_int + temp_dec;
`ifdef DHT11_FAULT_INJECT_EN
    assign checksum_tx = checksum ^ {7'b0, corrupt_checksum};
`else
    assign checksum_tx = checksum;
`endif

    assign tick       = (pre == PW'(TICKS_PER_US - 1));
    assign phase_done = tick && (us_cnt == phase_len - 15'd1);

    assign busy = !(state == IDLE || state == HOST_LOW);
    assign transmission_line =
        (state == ACK_LOW || state == BIT_LOW || state == END_LOW) ? 1'b0 : 1'bz;

    always_comb begin
        phase_len = 15'd0;
        case (state)
            WAIT_RESP:         phase_len = 15'(RESP_DELAY_US);
            ACK_LOW, ACK_HIGH: phase_len = 15'(ACK_US);
            BIT_LOW, END_LOW:  phase_len = 15'(BIT_LOW_US);
            BIT_HIGH:          phase_len = frame[bit_idx] ? 15'(BIT1_HIGH_US) : 15'(BIT0_HIGH_US);
            default:           phase_len = 15'd0;
        endcase
    end

    always_comb begin
        state_n  = state;
        latch    = 1'b0;
        done_set = 1'b0;
        case (state)
            IDLE:      if (armed && !line_s2) state_n = HOST_LOW;
            HOST_LOW:
                if (line_s2) begin
                    if (us_cnt >= 15'(MIN_START_US)) begin
                        state_n = WAIT_RESP;
                        latch   = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            WAIT_RESP: if (phase_done) state_n = ACK_LOW;
            ACK_LOW:   if (phase_done) state_n = ACK_HIGH;
            ACK_HIGH:  if (phase_done) state_n = BIT_LOW;
            BIT_LOW:   if (phase_done) state_n = BIT_HIGH;
            BIT_HIGH:  if (phase_done) state_n = (bit_idx == 6'd0) ? END_LOW : BIT_LOW;
            END_LOW:
                if (phase_done) begin
                    state_n  = IDLE;
                    done_set = 1'b1;
                end
            default:   state_n = IDLE;
        endcase
        if (!enable) begin
            state_n  = IDLE;
            latch    = 1'b0;
            done_set = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            line_s1    <= 1'b1;
            line_s2    <= 1'b1;
            armed      <= 1'b0;
            pre        <= '0;
            us_cnt     <= '0;
            frame      <= '0;
            bit_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            line_s1    <= transmission_line;
            line_s2    <= line_s1;
            // A new start needs the line seen high while idle, so our own END_LOW cannot retrigger.
            armed      <= (state == IDLE) && line_s2;
            frame_done <= done_set;
            if (latch)
                frame <= {hum_int, hum_dec, temp_int, temp_dec, checksum_tx};
            if (state == ACK_HIGH && state_n == BIT_LOW)
                bit_idx <= 6'd39;
            else if (state == BIT_HIGH && state_n == BIT_LOW)
                bit_idx <= bit_idx - 6'd1;
            if (state_n != state) begin
                if (state == IDLE && state_n == HOST_LOW) begin
                    pre    <= PRE_START;
                    us_cnt <= US_START;
                end else begin
                    pre    <= '0;
                    us_cnt <= '0;
                end
            end else if (tick) begin
                pre <= '0;
                if (us_cnt != 15'h7FFF)
                    us_cnt <= us_cnt + 15'd1;
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// tb/tb_dht11_responder.sv - table-driven bench decoding DHT11 frames from the line
module tb_dht11_responder;

    logic       clock = 1'b0;
    logic       reset, enable, host_low;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
`ifdef DHT11_FAULT_INJECT_EN
    logic       corrupt;
`endif
    wire        line;
    logic       busy, frame_done;

    int checks = 0;
    int failures = 0;
    int fd_count = 0;

    pullup (line);
    assign line = host_low ? 1'b0 : 1'bz;

    dht11_responder #(.TICKS_PER_US(1), .MIN_START_US(18)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .hum_int(hum_int),
        .hum_dec(hum_dec),
        .temp_int(temp_int),
        .temp_dec(temp_dec),
`ifdef DHT11_FAULT_INJECT_EN
        .corrupt_checksum(corrupt),
`endif
        .transmission_line(line),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (frame_done === 1'b1) fd_count++;

    typedef struct {
        logic [7:0] hi, hd, ti, td;
        logic       corrupt;
        int         low_us;
        logic [7:0] exp_cs;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        hum_int = v.hi; hum_dec = v.hd; temp_int = v.ti; temp_dec = v.td;
`ifdef DHT11_FAULT_INJECT_EN
        corrupt = v.corrupt;
`endif
    endtask

    task automatic host_start(input int low_us);
        repeat (10) @(posedge clock);
        #1 host_low = 1'b1;
        repeat (low_us) @(posedge clock);
        #1 host_low = 1'b0;
    endtask

    // Counts negedge samples while the line stays at lvl; bounded so a stuck line cannot hang.
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (((line === 1'b1) == lvl) && n < 400) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic read_frame(input int nbits, input logic scramble, output logic [39:0] bits,
                              output int gap, output int ackl, output int ackh,
                              output int endl, output int terr, output logic busy_seen);
        int n;
        bits = '0;
        terr = 0;
        endl = 0;
        @(negedge clock);
        measure(1'b1, gap);
        busy_seen = busy;
        measure(1'b0, ackl);
        if (scramble) begin
            hum_int = ~hum_int; hum_dec = hum_dec + 8'd3;
            temp_int = ~temp_int; temp_dec = temp_dec ^ 8'h5A;
        end
        measure(1'b1, ackh);
        for (int i = 0; i < nbits; i++) begin
            measure(1'b0, n);
            if (n != 50) terr++;
            measure(1'b1, n);
            if (n == 70) bits = {bits[38:0], 1'b1};
            else if (n == 27) bits = {bits[38:0], 1'b0};
            else terr++;
        end
        if (nbits == 40) measure(1'b0, endl);
    endtask

    task automatic run_frame(input vec_t v);
        logic [39:0] bits;
        int gap, ackl, ackh, endl, terr, fd0;
        logic busy_seen;
        apply(v);
        fd0 = fd_count;
        host_start(v.low_us);
        read_frame(40, 1'b1, bits, gap, ackl, ackh, endl, terr, busy_seen);
        repeat (5) @(negedge clock);
        // Release-to-ACK is the 30 us delay plus 2 sync flops and 1 decision cycle.
        check("gap", gap, 33);
        check("ack_low", ackl, 80);
        check("ack_high", ackh, 80);
        check("busy_in_frame", int'(busy_seen), 1);
        check("hum_int", int'(bits[39:32]), int'(v.hi));
        check("hum_dec", int'(bits[31:24]), int'(v.hd));
        check("temp_int", int'(bits[23:16]), int'(v.ti));
        check("temp_dec", int'(bits[15:8]), int'(v.td));
        check("checksum", int'(bits[7:0]), int'(v.exp_cs));
        check("bit_timing_errors", terr, 0);
        check("end_low", endl, 50);
        check("frame_done_pulses", fd_count - fd0, 1);
        check("busy_after", int'(busy), 0);
    endtask

    initial begin
        logic [39:0] bits;
        int gap, ackl, ackh, endl, terr, fd0, lows, busys;
        logic busy_seen;

        vecs.push_back('{8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 20, 8'h50});
        vecs.push_back('{8'hFF, 8'hFF, 8'hFF, 8'h01, 1'b0, 18, 8'hFE});
        vecs.push_back('{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 25, 8'h00});
        vecs.push_back('{8'hA5, 8'h5A, 8'h01, 8'h02, 1'b0, 19, 8'h02});
`ifdef DHT11_FAULT_INJECT_EN
        vecs.push_back('{8'h37, 8'h00, 8'h19, 8'h00, 1'b1, 20, 8'h51});
`endif

        reset = 1'b1; enable = 1'b1; host_low = 1'b0;
        apply(vecs[0]);
        repeat (3) @(posedge clock);
        #1;
        check("reset_line", int'(line === 1'b1), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_done", int'(frame_done), 0);
        reset = 1'b0;

        foreach (vecs[i]) run_frame(vecs[i]);

        // 17 us is one short of the start threshold: must be ignored.
        apply(vecs[0]);
        host_start(17);
        lows = 0; busys = 0;
        repeat (80) begin
            @(negedge clock);
            if (line !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        check("glitch_line_driven", lows, 0);
        check("glitch_busy", busys, 0);
        run_frame('{8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 18, 8'h50});

        // Drop enable in the low phase of bit 20.
        apply(vecs[0]);
        fd0 = fd_count;
        host_start(20);
        read_frame(20, 1'b0, bits, gap, ackl, ackh, endl, terr, busy_seen);
        check("en_bits_prefix", int'(bits[19:0]), int'(40'h3700190050 >> 20));
        enable = 1'b0;
        @(posedge clock);
        #1;
        check("en_off_line", int'(line === 1'b1), 1);
        check("en_off_busy", int'(busy), 0);
        lows = 0;
        repeat (100) begin
            @(negedge clock);
            if (line !== 1'b1) lows++;
        end
        check("en_off_lows", lows, 0);
        check("en_off_frame_done", fd_count - fd0, 0);
        enable = 1'b1;
        run_frame(vecs[1]);

        // Reset in the middle of ACK_LOW.
        apply(vecs[0]);
        host_start(20);
        @(negedge clock);
        measure(1'b1, gap);
        repeat (10) @(negedge clock);
        check("rst_in_ack_low", int'(line === 1'b0), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_line", int'(line === 1'b1), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        @(negedge clock);
        reset = 1'b0;
        run_frame(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
